// File: rtl/jt12_pkg.sv
// Shared definitions for the FM core timer slice: register 0x27 bit map and
// default timer geometry.
package jt12_pkg;

    // Register 0x27 bit positions
    localparam int LOADA = 0;
    localparam int LOADB = 1;
    localparam int ENA   = 2;
    localparam int ENB   = 3;
    localparam int CLRA  = 4;
    localparam int CLRB  = 5;

    localparam int CNTA_W_DEF = 10;
    localparam int CNTB_W_DEF = 8;
    localparam int PRESCB_DEF = 16;

    // Prescaler register width; a divide-by-one timer still keeps a 1-bit stub.
    function automatic int presc_bits(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/jt12_timers_if.sv
// Register-side bundle of the timer block: start values and reg 0x27 controls
// in, status flags, CSM overflow window and IRQ out.
interface jt12_timers_if #(
    parameter int CNTA_W = 10,
    parameter int CNTB_W = 8
);
    logic [CNTA_W-1:0] value_A;
    logic [CNTB_W-1:0] value_B;
    logic              load_A;
    logic              load_B;
    logic              enable_irq_A;
    logic              enable_irq_B;
    logic              clr_flag_A;
    logic              clr_flag_B;
    logic              flag_A;
    logic              flag_B;
    logic              overflow_A;
    logic              irq_n;

    modport master (
        output value_A, value_B, load_A, load_B,
        output enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B,
        input  flag_A, flag_B, overflow_A, irq_n
    );

    modport slave (
        input  value_A, value_B, load_A, load_B,
        input  enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B,
        output flag_A, flag_B, overflow_A, irq_n
    );

endinterface

// File: rtl/jt12_timer_cnt.sv
// One YM2612-style timer: load edge detect, tick prescaler, up-counter with
// auto-reload, status flag and a one-sample-wide overflow window.
module jt12_timer_cnt
    import jt12_pkg::*;
#(
    parameter int CW    = 10,
    parameter int PRESC = 1
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          clk_en,
    input  logic          zero,
    input  logic [CW-1:0] value,
    input  logic          load,
    input  logic          enable_irq,
    input  logic          clr_flag,
    output logic          flag,
    output logic          overflow
);

    localparam int PW = presc_bits(PRESC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic          load_l;
    logic [PW-1:0] presc;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          step;
    logic          wrap;

    // A load edge takes priority over a coincident tick: the cycle only loads.
    always_comb begin
        rise = load & ~load_l;
        step = load & zero & ~rise & (presc == PRESC_LAST);
        wrap = step & (cnt == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_l   <= 1'b0;
            presc    <= '0;
            cnt      <= '0;
            flag     <= 1'b0;
            overflow <= 1'b0;
        end else if (clk_en) begin
            load_l <= load;
            if (rise) begin
                cnt   <= value;
                presc <= '0;
            end else if (load && zero) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
                if (step)
                    cnt <= wrap ? value : cnt + CW'(1);
            end
            // Overflow window spans one whole sample: refreshed on every tick.
            if (zero)
                overflow <= wrap;
            // Set beats clear so a coincident overflow is never lost.
            if (wrap && enable_irq)
                flag <= 1'b1;
            else if (clr_flag)
                flag <= 1'b0;
        end
    end

endmodule

// File: rtl/jt12_timers.sv
// Timer A / Timer B of the FM core: two timer instances plus the registered,
// active-low IRQ combining both status flags.
module jt12_timers
    import jt12_pkg::*;
#(
    parameter int CNTA_W = CNTA_W_DEF,
    parameter int CNTB_W = CNTB_W_DEF,
    parameter int PRESCB = PRESCB_DEF
) (
    input  logic         rst_n,
    input  logic         clk,
    input  logic         clk_en,
    input  logic         zero,
    jt12_timers_if.slave regs
);

    logic flag_A;
    logic flag_B;
    logic overflow_A;
    logic unused_ovf_B;
    logic irq_n;

    jt12_timer_cnt #(
        .CW   (CNTA_W),
        .PRESC(1)
    ) u_timer_a (
        .rst_n     (rst_n),
        .clk       (clk),
        .clk_en    (clk_en),
        .zero      (zero),
        .value     (regs.value_A),
        .load      (regs.load_A),
        .enable_irq(regs.enable_irq_A),
        .clr_flag  (regs.clr_flag_A),
        .flag      (flag_A),
        .overflow  (overflow_A)
    );

    // Timer B has no CSM role; its overflow window is left unused.
    jt12_timer_cnt #(
        .CW   (CNTB_W),
        .PRESC(PRESCB)
    ) u_timer_b (
        .rst_n     (rst_n),
        .clk       (clk),
        .clk_en    (clk_en),
        .zero      (zero),
        .value     (regs.value_B),
        .load      (regs.load_B),
        .enable_irq(regs.enable_irq_B),
        .clr_flag  (regs.clr_flag_B),
        .flag      (flag_B),
        .overflow  (unused_ovf_B)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_n <= 1'b1;
        else if (clk_en)
            irq_n <= ~(flag_A | flag_B);
    end

    assign regs.flag_A     = flag_A;
    assign regs.flag_B     = flag_B;
    assign regs.overflow_A = overflow_A;
    assign regs.irq_n      = irq_n;

endmodule

// File: tb/tb_jt12_timers.sv
// Bench for jt12_timers: directed scenarios plus randomized traffic checked
// against a steps-remaining reference model of both timers.
module tb_jt12_timers;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b0;
    logic zero   = 1'b0;

    jt12_timers_if #(.CNTA_W(10), .CNTB_W(8)) regs ();

    jt12_timers #(.CNTA_W(10), .CNTB_W(8), .PRESCB(16)) dut (
        .rst_n (rst_n),
        .clk   (clk),
        .clk_en(clk_en),
        .zero  (zero),
        .regs  (regs)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: sample ticks left until the next overflow of each timer.
    int m_rem_a, m_rem_b, m_tick_b;
    bit m_prev_a, m_prev_b, m_ovf_a, m_flag_a, m_flag_b, m_irq_n;

    task automatic model_reset();
        m_rem_a  = 1024;
        m_rem_b  = 256;
        m_tick_b = 0;
        m_prev_a = 0;
        m_prev_b = 0;
        m_ovf_a  = 0;
        m_flag_a = 0;
        m_flag_b = 0;
        m_irq_n  = 1;
    endtask

    task automatic model_step();
        bit ev_a, ev_b;
        if (!clk_en) return;
        ev_a = 0;
        ev_b = 0;
        if (regs.load_A && !m_prev_a) begin
            m_rem_a = 1024 - int'(regs.value_A);
        end else if (regs.load_A && zero) begin
            m_rem_a = m_rem_a - 1;
            if (m_rem_a == 0) begin
                ev_a = 1;
                m_rem_a = 1024 - int'(regs.value_A);
            end
        end
        if (regs.load_B && !m_prev_b) begin
            m_tick_b = 0;
            m_rem_b  = 256 - int'(regs.value_B);
        end else if (regs.load_B && zero) begin
            m_tick_b = m_tick_b + 1;
            if (m_tick_b % 16 == 0) begin
                m_rem_b = m_rem_b - 1;
                if (m_rem_b == 0) begin
                    ev_b = 1;
                    m_rem_b = 256 - int'(regs.value_B);
                end
            end
        end
        if (zero) m_ovf_a = ev_a;
        m_irq_n = !(m_flag_a || m_flag_b);
        if (ev_a && regs.enable_irq_A) m_flag_a = 1;
        else if (regs.clr_flag_A)      m_flag_a = 0;
        if (ev_b && regs.enable_irq_B) m_flag_b = 1;
        else if (regs.clr_flag_B)      m_flag_b = 0;
        m_prev_a = regs.load_A;
        m_prev_b = regs.load_B;
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled 1 after rise.
    task automatic step(input bit z, input bit ce);
        @(negedge clk);
        zero   = z;
        clk_en = ce;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step(1, 1);
        step(0, 1);
        step(0, 1);
    endtask

    task automatic test_reset();
        tests++; if (regs.flag_A !== 1'b0) begin fails++; $display("FAIL reset_flag_A: got %b expected 0", regs.flag_A); end
        tests++; if (regs.flag_B !== 1'b0) begin fails++; $display("FAIL reset_flag_B: got %b expected 0", regs.flag_B); end
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL reset_ovf_A: got %b expected 0", regs.overflow_A); end
        tests++; if (regs.irq_n !== 1'b1) begin fails++; $display("FAIL reset_irq_n: got %b expected 1", regs.irq_n); end
    endtask

    task automatic test_timer_a();
        regs.value_A = 10'd1020;
        regs.enable_irq_A = 1;
        regs.load_A = 1;
        step(0, 1);
        for (int t = 1; t <= 3; t++) begin
            tick();
            tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL ta_early_ovf tick%0d: got %b expected 0", t, regs.overflow_A); end
        end
        step(1, 1);
        tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL ta_ovf_tick4: got %b expected 1", regs.overflow_A); end
        tests++; if (regs.flag_A !== 1'b1) begin fails++; $display("FAIL ta_flag: got %b expected 1", regs.flag_A); end
        tests++; if (regs.irq_n !== 1'b1) begin fails++; $display("FAIL ta_irq_lag: got %b expected 1", regs.irq_n); end
        step(0, 1);
        tests++; if (regs.irq_n !== 1'b0) begin fails++; $display("FAIL ta_irq: got %b expected 0", regs.irq_n); end
        tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL ta_ovf_window: got %b expected 1", regs.overflow_A); end
        step(0, 1);
        step(1, 1);
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL ta_ovf_tick5: got %b expected 0", regs.overflow_A); end
        step(0, 1);
        step(0, 1);
        tick();
        tick();
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL ta_reload_early: got %b expected 0", regs.overflow_A); end
        tick();
        tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL ta_reload_ovf: got %b expected 1", regs.overflow_A); end
        regs.load_A = 0;
        regs.clr_flag_A = 1;
        step(0, 1);
        regs.clr_flag_A = 0;
        step(0, 1);
        tests++; if (regs.flag_A !== 1'b0) begin fails++; $display("FAIL ta_clear: got %b expected 0", regs.flag_A); end
    endtask

    task automatic test_back_to_back();
        regs.value_A = 10'd1023;
        regs.enable_irq_A = 1;
        regs.load_A = 1;
        step(0, 1);
        for (int t = 1; t <= 6; t++) begin
            step(1, 1);
            tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL b2b_ovf_tick%0d: got %b expected 1", t, regs.overflow_A); end
            step(0, 1);
            tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL b2b_ovf_gap%0d: got %b expected 1", t, regs.overflow_A); end
        end
        regs.enable_irq_A = 0;
        tick();
        tests++; if (regs.flag_A !== 1'b1) begin fails++; $display("FAIL b2b_flag_kept: got %b expected 1", regs.flag_A); end
        regs.clr_flag_A = 1;
        step(0, 1);
        regs.clr_flag_A = 0;
        tests++; if (regs.flag_A !== 1'b0) begin fails++; $display("FAIL b2b_flag_clr: got %b expected 0", regs.flag_A); end
        step(0, 1);
        tests++; if (regs.irq_n !== 1'b1) begin fails++; $display("FAIL b2b_irq_release: got %b expected 1", regs.irq_n); end
    endtask

    task automatic test_set_wins();
        regs.enable_irq_A = 1;
        tick();
        tests++; if (regs.flag_A !== 1'b1) begin fails++; $display("FAIL sw_flag_set: got %b expected 1", regs.flag_A); end
        regs.clr_flag_A = 1;
        step(1, 1);
        regs.clr_flag_A = 0;
        tests++; if (regs.flag_A !== 1'b1) begin fails++; $display("FAIL sw_set_wins: got %b expected 1", regs.flag_A); end
        regs.clr_flag_A = 1;
        step(0, 1);
        regs.clr_flag_A = 0;
        tests++; if (regs.flag_A !== 1'b0) begin fails++; $display("FAIL sw_clear: got %b expected 0", regs.flag_A); end
        regs.load_A = 0;
        regs.enable_irq_A = 0;
        tick();
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL sw_stop_ovf: got %b expected 0", regs.overflow_A); end
    endtask

    task automatic test_timer_b();
        regs.value_B = 8'd254;
        regs.enable_irq_B = 1;
        regs.load_B = 1;
        step(0, 1);
        for (int t = 1; t <= 31; t++) begin
            tick();
            tests++; if (regs.flag_B !== 1'b0) begin fails++; $display("FAIL tb_early_flag tick%0d: got %b expected 0", t, regs.flag_B); end
            tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL tb_ovf_A tick%0d: got %b expected 0", t, regs.overflow_A); end
        end
        step(1, 1);
        tests++; if (regs.flag_B !== 1'b1) begin fails++; $display("FAIL tb_flag_tick32: got %b expected 1", regs.flag_B); end
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL tb_ovf_A_tick32: got %b expected 0", regs.overflow_A); end
        step(0, 1);
        tests++; if (regs.irq_n !== 1'b0) begin fails++; $display("FAIL tb_irq: got %b expected 0", regs.irq_n); end
        regs.load_B = 0;
        regs.enable_irq_B = 0;
        regs.clr_flag_B = 1;
        step(0, 1);
        regs.clr_flag_B = 0;
        step(0, 1);
        tests++; if (regs.flag_B !== 1'b0) begin fails++; $display("FAIL tb_clear: got %b expected 0", regs.flag_B); end
    endtask

    task automatic test_stop_restart();
        regs.value_A = 10'd1000;
        regs.load_A = 1;
        step(0, 1);
        repeat (10) tick();
        regs.load_A = 0;
        repeat (5) tick();
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL sr_frozen: got %b expected 0", regs.overflow_A); end
        regs.load_A = 1;
        step(0, 1);
        for (int t = 1; t <= 23; t++) begin
            tick();
            tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL sr_early tick%0d: got %b expected 0", t, regs.overflow_A); end
        end
        tick();
        tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL sr_ovf_tick24: got %b expected 1", regs.overflow_A); end
    endtask

    task automatic test_clk_en_hold();
        regs.load_A = 0;
        for (int t = 1; t <= 4; t++) begin
            step(1, 0);
            tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL ce_hold%0d: got %b expected 1", t, regs.overflow_A); end
        end
        regs.load_A = 1;
        step(1, 1);
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL ce_resume: got %b expected 0", regs.overflow_A); end
        tests++; if (regs.overflow_A !== m_ovf_a) begin fails++; $display("FAIL ce_model: got %b expected %b", regs.overflow_A, m_ovf_a); end
    endtask

    task automatic test_async_reset();
        regs.value_A = 10'd1023;
        regs.enable_irq_A = 1;
        regs.load_A = 0;
        step(0, 1);
        regs.load_A = 1;
        step(0, 1);
        tick();
        tests++; if ({regs.overflow_A, regs.flag_A, regs.irq_n} !== 3'b110) begin fails++; $display("FAIL ar_setup: got %b expected 110", {regs.overflow_A, regs.flag_A, regs.irq_n}); end
        #2;
        rst_n = 0;
        regs.load_A = 0;
        model_reset();
        #1;
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL ar_ovf: got %b expected 0", regs.overflow_A); end
        tests++; if (regs.flag_A !== 1'b0) begin fails++; $display("FAIL ar_flag: got %b expected 0", regs.flag_A); end
        tests++; if (regs.irq_n !== 1'b1) begin fails++; $display("FAIL ar_irq: got %b expected 1", regs.irq_n); end
        @(negedge clk);
        rst_n = 1;
        repeat (5) tick();
        tests++; if (regs.overflow_A !== 1'b0 || regs.flag_A !== 1'b0) begin fails++; $display("FAIL ar_idle: got ovf=%b flag=%b expected 0 0", regs.overflow_A, regs.flag_A); end
        regs.value_A = 10'd1020;
        regs.load_A = 1;
        step(0, 1);
        repeat (3) tick();
        tests++; if (regs.overflow_A !== 1'b0) begin fails++; $display("FAIL ar_restart_early: got %b expected 0", regs.overflow_A); end
        tick();
        tests++; if (regs.overflow_A !== 1'b1) begin fails++; $display("FAIL ar_restart_ovf: got %b expected 1", regs.overflow_A); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(49) == 0) regs.load_A = ~regs.load_A;
            if ($urandom_range(49) == 0) regs.load_B = ~regs.load_B;
            if ($urandom_range(29) == 0) regs.enable_irq_A = ~regs.enable_irq_A;
            if ($urandom_range(29) == 0) regs.enable_irq_B = ~regs.enable_irq_B;
            regs.clr_flag_A = ($urandom_range(19) == 0);
            regs.clr_flag_B = ($urandom_range(19) == 0);
            regs.value_A = 10'(1015 + $urandom_range(8));
            regs.value_B = 8'(250 + $urandom_range(5));
            step($urandom_range(2) == 0, $urandom_range(7) != 0);
            tests++;
            if ({regs.overflow_A, regs.flag_A, regs.flag_B, regs.irq_n} !== {m_ovf_a, m_flag_a, m_flag_b, m_irq_n}) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rnd cycle%0d: got ovf/fA/fB/irq=%b expected %b", c,
                             {regs.overflow_A, regs.flag_A, regs.flag_B, regs.irq_n},
                             {m_ovf_a, m_flag_a, m_flag_b, m_irq_n});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        regs.value_A      = '0;
        regs.value_B      = '0;
        regs.load_A       = 0;
        regs.load_B       = 0;
        regs.enable_irq_A = 0;
        regs.enable_irq_B = 0;
        regs.clr_flag_A   = 0;
        regs.clr_flag_B   = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1;
        step(0, 1);
        test_reset();
        test_timer_a();
        test_back_to_back();
        test_set_wins();
        test_timer_b();
        test_stop_restart();
        test_clk_en_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jt12_timers.md
Name: jt12_timers

Overview:
- Timer A / Timer B block of the FM core.
- Directly upstream of the key-on stage: produces overflow_A, which the key-on stage combines with csm to force channel-3 key-on.
- Also produces the status flags and the IRQ line read by the CPU interface.
- Ticks once per FM sample (zero pulse from the slot counter), qualified by clk_en.

Parameters:
- CNTA_W, 10, Timer A counter width.
- CNTB_W, 8, Timer B counter width.
- PRESCB, 16, number of sample ticks per Timer B count step (power of two).

Ports:
- rst_n  in  1  asynchronous active-low reset.
- clk  in  1  core clock.
- clk_en  in  1  clock enable; all state advances only when high.
- zero  in  1  sample tick, one clk_en cycle per 24-slot round.
- value_A  in  CNTA_W  Timer A start value (regs 0x24/0x25).
- value_B  in  CNTB_W  Timer B start value (reg 0x26).
- load_A, load_B  in  1  run bits (reg 0x27 b0/b1), level.
- enable_irq_A, enable_irq_B  in  1  flag enables (reg 0x27 b2/b3), level.
- clr_flag_A, clr_flag_B  in  1  flag reset strobes (reg 0x27 b4/b5), one clk_en cycle.
- flag_A, flag_B  out  1  status flags.
- overflow_A  out  1  Timer A overflow window, for CSM key-on.
- irq_n  out  1  active-low interrupt.

Behaviour:
- Reset values: counters 0, prescaler 0, flag_A = flag_B = 0, overflow_A = 0, irq_n = 1, load edge registers 0.
- Start: a 0->1 transition of load_A, detected on a clk_en cycle, loads cnt_A <= value_A on that same cycle.
- Run: while load_A = 1, each zero tick increments cnt_A.
- Stop: while load_A = 0, cnt_A holds its value.
- Timer A overflow: on a zero tick with cnt_A = all ones (1023):
  - cnt_A <= value_A (auto-reload);
  - overflow_A <= 1;
  - if enable_irq_A = 1, flag_A <= 1.
- overflow_A shape: stays high until the next zero tick, i.e. a full 24-slot window, so the key-on stage sees it on every channel-3 operator slot. Back-to-back overflows (value_A = 1023) keep it high continuously.
- Timer B:
  - 4-bit prescaler (log2 PRESCB bits) increments on every zero tick while load_B = 1; it is cleared on the load_B rising edge.
  - cnt_B steps only on a tick where the prescaler = PRESCB-1.
  - Load, reload and overflow follow the same rules as Timer A with value_B and cnt_B = 255.
  - Timer B has no overflow output; it only sets flag_B when enable_irq_B = 1.
- Flag clear: clr_flag_x = 1 on a clk_en cycle clears flag_x.
- Flag set versus clear in the same clk_en cycle: the set wins, so no overflow event is lost.
- enable_irq_x = 0 does not clear an already-set flag.
- irq_n is registered: irq_n <= ~(flag_A | flag_B), one clk_en cycle after a flag changes.
- load_x falling mid-count: the counter freezes and no overflow is generated. A later rising edge reloads from value_x; it does not resume.
- value_x written while running: takes effect at the next reload or load edge only.
- clk_en = 0: all state is held, including edge detection.
- rst_n assertion mid-count: everything returns to reset values immediately (asynchronous); operation restarts only after a new load rising edge.

Decomposition:
- Shared package jt12_pkg: register-0x27 bit positions (LOADA=0, LOADB=1, ENA=2, ENB=3, CLRA=4, CLRB=5) and default widths.
- One sub-module, jt12_timer_cnt, instantiated twice and parameterised by width and prescale.
  - Contents: load edge detect, prescaler, counter, reload, flag and overflow.
  - Timer A instance uses prescale 1; Timer B instance uses prescale PRESCB.
- Top level: the IRQ OR and register.

Test Plan:
- value_A=1020, load_A 0->1, enable_irq_A=1 -> overflow_A rises on the 4th zero tick and stays high until the 5th tick; flag_A=1; irq_n=0 one clk_en cycle later; cnt_A reloads to 1020.
- value_A=1023, load_A held 1 -> overflow_A high continuously from the first tick; clearing enable_irq_A leaves flag_A set; pulsing clr_flag_A then clears it.
- value_B=254, load_B=1, enable_irq_B=1 -> flag_B sets on the 32nd zero tick, not earlier; overflow_A stays 0 throughout.
- clr_flag_A pulsed on the same clk_en cycle as an A overflow -> flag_A remains 1.
- value_A=1000, load_A dropped after 10 ticks and raised again -> counter restarts at 1000; overflow occurs 24 ticks after the new rising edge.
- rst_n asserted while overflow_A=1 and flag_A=1 -> immediately overflow_A=0, flag_A=0, irq_n=1; no ticks counted until a new load_A edge.
